piso_shift_tx: RTL and testbench
================================

// Module: piso_shift_tx
// PURPOSE
//   Parallel-in/serial-out transmitter; the sending end of the team's serial capture flip-flop chain.
//   Accepts a WIDTH-bit word over a valid/ready load handshake, then emits it one bit per shift_en strobe.
//   Sits between a parallel data source and a serial link whose SIPO receiver samples sdo on the same strobe.
// PARAMETERS
//   WIDTH      8   data word width in bits; legal range >= 2
//   MSB_FIRST  1   1: bit WIDTH-1 is sent first; 0: bit 0 is sent first
// PORTS
//   clk          in   1      clock, all state updates on posedge
//   rst          in   1      reset, asynchronous, active-high
//   load_valid   in   1      source presents load_data
//   load_ready   out  1      block can accept a word (high only in IDLE)
//   load_data    in   WIDTH  parallel word to transmit
//   shift_en     in   1      bit strobe; one bit is consumed per cycle it is high in SHIFT
//   sdo          out  1      serial data out, registered
//   sdo_valid    out  1      sdo holds a frame bit (high throughout SHIFT)
//   frame_start  out  1      1-cycle pulse the cycle the first bit first appears on sdo
//   done         out  1      1-cycle pulse after the last bit is consumed
//   busy         out  1      high in SHIFT
// BEHAVIOUR
//   - Reset (async, any state): state=IDLE, shift register=0, bit count=0; outputs load_ready=1,
//     sdo=0, sdo_valid=0, frame_start=0, done=0, busy=0. A frame in progress is aborted; no done pulse.
//   - FSM: IDLE, SHIFT.
//   - IDLE: load_ready=1. On edge with load_valid=1: capture load_data, count<=0, go SHIFT; the first
//     bit is on sdo and sdo_valid=1, busy=1, frame_start=1 in the next cycle (1-cycle load latency).
//     shift_en in IDLE is ignored.
//   - SHIFT: load_ready=0; load_valid ignored, load_data not sampled. Each edge with shift_en=1 advances
//     sdo to the next bit (shift toward the output end, MSB_FIRST selects direction) and increments count.
//     shift_en=0 holds sdo and count indefinitely (no timeout).
//   - Frame length N = WIDTH (WIDTH+1 with parity option). The edge with shift_en=1 while count=N-1
//     exits to IDLE: next cycle sdo=0, sdo_valid=0, busy=0, load_ready=1, done=1 for exactly one cycle.
//   - Back-to-back: a load accepted during the done cycle is legal; the next frame's first bit appears
//     the following cycle, giving one idle cycle between frames.
//   - Count width $clog2(WIDTH+2); never wraps in normal operation; count is 0 in IDLE.
//   - frame_start and done never assert in the same cycle; done never asserts without a prior frame_start.
// CONFIGURATION
//   PISO_PARITY_EN defined: after the WIDTH data bits one even-parity bit (XOR of the captured word)
//     is sent on sdo as bit N-1, N=WIDTH+1; done follows consumption of the parity bit.
//   PISO_PARITY_EN undefined: no parity logic; N=WIDTH; done follows the last data bit.
// TESTING
//   1 Reset: assert rst mid-sim, no clock -> all outputs at reset values immediately; load_ready=1.
//   2 WIDTH=8, MSB_FIRST=1, load 8'hA5, shift_en high continuously -> sdo 1,0,1,0,0,1,0,1 on 8
//     consecutive cycles; frame_start on the first; done on the 9th cycle after the load cycle.
//   3 MSB_FIRST=0, load 8'h01, shift_en high every 3rd cycle -> sdo 1 then seven 0s, each bit held
//     3 cycles; load_valid pulses during SHIFT have no effect; load_ready stays 0.
//   4 Back-to-back: load 8'hFF, then hold load_valid with 8'h00 -> second word accepted in the done
//     cycle; sdo 8x1, one idle cycle (sdo_valid=0), then 8x0.
//   5 Abort: load 8'hC3, after 4 bits assert rst for 1 cycle -> sdo=0, sdo_valid=0, no done; next load
//     of 8'h3C transmits cleanly from bit 7.
//   6 PISO_PARITY_EN defined: load 8'h07 -> 8 data bits then parity bit 1; load 8'h03 -> parity 0;
//     done after the 9th strobe in both cases.

Source files
------------

// File: rtl/piso_shift_tx_if.sv
// piso_shift_tx_if: load handshake, bit strobe and serial outputs of the PISO transmitter.
interface piso_shift_tx_if #(
    parameter int WIDTH = 8
);
    logic             load_valid;
    logic             load_ready;
    logic [WIDTH-1:0] load_data;
    logic             shift_en;
    logic             sdo;
    logic             sdo_valid;
    logic             frame_start;
    logic             done;
    logic             busy;
    modport master (
        output load_valid, load_data, shift_en,
        input  load_ready, sdo, sdo_valid, frame_start, done, busy
    );
    modport slave (
        input  load_valid, load_data, shift_en,
        output load_ready, sdo, sdo_valid, frame_start, done, busy
    );
endinterface

// File: rtl/piso_shift_tx.sv
// piso_shift_tx: parallel-in/serial-out transmitter, valid/ready load then one bit per shift_en strobe.
// Define PISO_PARITY_EN to append an even-parity bit after the data bits.
module piso_shift_tx #(
    parameter int WIDTH     = 8,
    parameter bit MSB_FIRST = 1'b1
) (
    input logic            clk,
    input logic            rst,
    piso_shift_tx_if.slave bus
);
    localparam int CW = $clog2(WIDTH + 2);
`ifdef PISO_PARITY_EN
    localparam int N = WIDTH + 1;
`else
    localparam int N = WIDTH;
`endif
    typedef enum logic {IDLE, SHIFT} state_t;
    state_t        state, state_nx;
    logic [N-1:0]  sr, word;
    logic [CW-1:0] cnt;
    logic          frame_start, done, load, step, last;
    // The frame word is laid out so the output end always holds the next bit, parity last.
`ifdef PISO_PARITY_EN
    assign word = MSB_FIRST ? {bus.load_data, ^bus.load_data} : {^bus.load_data, bus.load_data};
`else
    assign word = bus.load_data;
`endif
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_nx;
    end
    always_comb begin
        state_nx = state;
        load     = state == IDLE && bus.load_valid;
        step     = state == SHIFT && bus.shift_en;
        last     = step && cnt == CW'(N - 1);
        state_nx = load ? SHIFT : last ? IDLE : state;
    end
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sr          <= '0;
            cnt         <= '0;
            frame_start <= 1'b0;
            done        <= 1'b0;
        end else begin
            frame_start <= load;
            done        <= last;
            if (load) begin
                sr  <= word;
                cnt <= '0;
            end else if (last) begin
                sr  <= '0;
                cnt <= '0;
            end else if (step) begin
                sr  <= MSB_FIRST ? sr << 1 : sr >> 1;
                cnt <= cnt + CW'(1);
            end
        end
    end
    assign bus.load_ready  = state == IDLE;
    assign bus.busy        = state == SHIFT;
    assign bus.sdo_valid   = state == SHIFT;
    assign bus.sdo         = MSB_FIRST ? sr[N-1] : sr[0];
    assign bus.frame_start = frame_start;
    assign bus.done        = done;
endmodule

// File: tb/tb_piso_shift_tx.sv
// tb_piso_shift_tx: MSB-first and LSB-first instances driven in lockstep, checked every cycle
// against a bit-list model, plus literal frame checks.
module tb_piso_shift_tx;
    localparam int W = 8;
`ifdef PISO_PARITY_EN
    localparam int N = W + 1;
    localparam bit PAR = 1'b1;
`else
    localparam int N = W;
    localparam bit PAR = 1'b0;
`endif
    logic clk = 1'b0;
    logic rst = 1'b1;
    int checks = 0;
    int failures = 0;
    piso_shift_tx_if #(.WIDTH(W)) if0 ();
    piso_shift_tx_if #(.WIDTH(W)) if1 ();
    piso_shift_tx #(.WIDTH(W), .MSB_FIRST(1'b1)) u0 (.clk(clk), .rst(rst), .bus(if0));
    piso_shift_tx #(.WIDTH(W), .MSB_FIRST(1'b0)) u1 (.clk(clk), .rst(rst), .bus(if1));
    always #5 clk = ~clk;

    // Model: each instance owns the list of bits it must send and an index into it.
    bit          m_busy [2];
    bit          m_fs   [2];
    bit          m_done [2];
    int          m_idx  [2];
    logic [15:0] m_bits [2];

    task automatic chk(string name, logic [15:0] act, logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s t=%0t got=%h want=%h", name, $time, act, exp);
        end
    endtask

    task automatic drive(logic lv, logic [W-1:0] d, logic se);
        if0.load_valid = lv;
        if1.load_valid = lv;
        if0.load_data  = d;
        if1.load_data  = d;
        if0.shift_en   = se;
        if1.shift_en   = se;
    endtask

    task automatic model_reset();
        for (int k = 0; k < 2; k++) begin
            m_busy[k] = 1'b0;
            m_fs[k]   = 1'b0;
            m_done[k] = 1'b0;
            m_idx[k]  = 0;
        end
    endtask

    task automatic model_step();
        logic [W-1:0] d;
        d = if0.load_data;
        if (rst) begin
            model_reset();
            return;
        end
        for (int k = 0; k < 2; k++) begin
            m_fs[k]   = 1'b0;
            m_done[k] = 1'b0;
            if (!m_busy[k]) begin
                if (if0.load_valid) begin
                    m_bits[k] = '0;
                    for (int i = 0; i < W; i++) m_bits[k][i] = (k == 0) ? d[W-1-i] : d[i];
                    if (PAR) m_bits[k][W] = ^d;
                    m_idx[k]  = 0;
                    m_busy[k] = 1'b1;
                    m_fs[k]   = 1'b1;
                end
            end else if (if0.shift_en) begin
                if (m_idx[k] == N - 1) begin
                    m_busy[k] = 1'b0;
                    m_done[k] = 1'b1;
                end else m_idx[k]++;
            end
        end
    endtask

    function automatic logic exp_sdo(int k);
        return m_busy[k] ? m_bits[k][m_idx[k]] : 1'b0;
    endfunction

    task automatic compare_all();
        chk("u0_sdo",         16'(if0.sdo),         16'(exp_sdo(0)));
        chk("u0_sdo_valid",   16'(if0.sdo_valid),   16'(m_busy[0]));
        chk("u0_busy",        16'(if0.busy),        16'(m_busy[0]));
        chk("u0_load_ready",  16'(if0.load_ready),  16'(!m_busy[0]));
        chk("u0_frame_start", 16'(if0.frame_start), 16'(m_fs[0]));
        chk("u0_done",        16'(if0.done),        16'(m_done[0]));
        chk("u1_sdo",         16'(if1.sdo),         16'(exp_sdo(1)));
        chk("u1_sdo_valid",   16'(if1.sdo_valid),   16'(m_busy[1]));
        chk("u1_busy",        16'(if1.busy),        16'(m_busy[1]));
        chk("u1_load_ready",  16'(if1.load_ready),  16'(!m_busy[1]));
        chk("u1_frame_start", 16'(if1.frame_start), 16'(m_fs[1]));
        chk("u1_done",        16'(if1.done),        16'(m_done[1]));
    endtask

    task automatic tick();
        @(posedge clk);
        model_step();
        @(negedge clk);
        compare_all();
    endtask

    // Load one word with shift_en held high and collect the serial stream of both instances.
    task automatic send(input logic [W-1:0] d, output logic [15:0] g0, output logic [15:0] g1);
        drive(1'b1, d, 1'b1);
        tick();
        drive(1'b0, '0, 1'b1);
        chk("send_frame_start", 16'(if0.frame_start), 16'd1);
        g0 = '0;
        g1 = '0;
        for (int i = 0; i < N; i++) begin
            g0 = {g0[14:0], if0.sdo};
            g1 = {g1[14:0], if1.sdo};
            tick();
        end
        chk("send_done", 16'(if0.done), 16'd1);
        drive(1'b0, '0, 1'b0);
    endtask

    initial begin
        logic [15:0] g0, g1;
        int ones, vld, gap, ones_a, ones_b;
        bit seen;
        model_reset();
        drive(1'b0, '0, 1'b0);
        @(negedge clk);
        compare_all();
        chk("reset_load_ready", 16'(if0.load_ready), 16'd1);
        rst = 1'b0;
        tick();
        // A5 with continuous strobe: 1,0,1,0,0,1,0,1 (A5 reads the same in either order)
        send(8'hA5, g0, g1);
        chk("a5_msb_bits", g0, PAR ? 16'h014A : 16'h00A5);
        chk("a5_lsb_bits", g1, PAR ? 16'h014A : 16'h00A5);
        tick();
        // 01 with strobe every 3rd cycle and stray load pulses during SHIFT
        drive(1'b1, 8'h01, 1'b0);
        tick();
        ones = 0;
        seen = 1'b0;
        for (int c = 0; c < 200 && !seen; c++) begin
            ones += int'(if1.sdo);
            drive(1'($urandom_range(0, 1)), W'($urandom), (c % 3) == 2);
            tick();
            seen = if1.done;
        end
        chk("lsb01_done_seen", 16'(seen), 16'd1);
        chk("lsb01_one_cycles", 16'(ones), PAR ? 16'd6 : 16'd3);
        drive(1'b0, '0, 1'b0);
        tick();
        // Back-to-back: FF then 00 accepted in the done cycle
        drive(1'b1, 8'hFF, 1'b1);
        tick();
        drive(1'b1, 8'h00, 1'b1);
        vld = 0;
        gap = 1;
        ones_a = 0;
        ones_b = 0;
        for (int c = 0; c < 2 * N + 1; c++) begin
            vld += int'(if0.sdo_valid);
            if (c < W) ones_a += int'(if0.sdo);
            if (c == N) gap = int'(if0.sdo_valid);
            if (c > N && c <= N + W) ones_b += int'(if0.sdo);
            tick();
        end
        drive(1'b0, '0, 1'b0);
        chk("b2b_valid_cycles", 16'(vld), 16'(2 * N));
        chk("b2b_gap", 16'(gap), 16'd0);
        chk("b2b_first_ones", 16'(ones_a), 16'd8);
        chk("b2b_second_ones", 16'(ones_b), 16'd0);
        chk("b2b_done_end", 16'(if0.done), 16'd1);
        tick();
        // Abort C3 after 4 bits with an asynchronous reset, then send 3C cleanly
        drive(1'b1, 8'hC3, 1'b1);
        tick();
        drive(1'b0, '0, 1'b1);
        repeat (4) tick();
        drive(1'b0, '0, 1'b0);
        #2 rst = 1'b1;
        model_reset();
        #1;
        chk("abort_sdo", 16'(if0.sdo), 16'd0);
        chk("abort_sdo_valid", 16'(if0.sdo_valid), 16'd0);
        chk("abort_busy", 16'(if0.busy), 16'd0);
        chk("abort_load_ready", 16'(if0.load_ready), 16'd1);
        chk("abort_done", 16'(if0.done), 16'd0);
        tick();
        rst = 1'b0;
        tick();
        send(8'h3C, g0, g1);
        chk("3c_msb_bits", g0, PAR ? 16'h0078 : 16'h003C);
        tick();
`ifdef PISO_PARITY_EN
        send(8'h07, g0, g1);
        chk("par07_msb_bits", g0, 16'h000F);
        chk("par07_lsb_bits", g1, 16'h01C1);
        tick();
        send(8'h03, g0, g1);
        chk("par03_msb_bits", g0, 16'h0006);
        tick();
`endif
        // Randomized traffic with occasional asynchronous resets
        for (int c = 0; c < 2000; c++) begin
            if ($urandom_range(0, 199) == 0) begin
                #2 rst = 1'b1;
                model_reset();
                #1;
                chk("rand_reset_load_ready", 16'(if1.load_ready), 16'd1);
                chk("rand_reset_sdo_valid", 16'(if1.sdo_valid), 16'd0);
                tick();
                rst = 1'b0;
            end else begin
                drive(1'($urandom_range(0, 1)), W'($urandom), $urandom_range(0, 9) < 7);
                tick();
            end
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
